// File: rtl/never8_control_if.sv
// Never8 sequencer bus bundle: instruction-fetch handshake and output port.
interface never8_control_if;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_data,
    input  imem_ack, imem_data, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_data,
    output imem_ack, imem_data, out_ready
  );
endinterface

// File: rtl/never8_control.sv
// Never8 fetch/decode/execute sequencer. Owns pc, ir, acc and flags,
// drives the ALU operands, and consumes ALU results in EXEC.
module never8_control (
  input  logic                     clk,
  input  logic                     reset_n,
  never8_control_if.master         bus,
  output logic [2:0]               alu_opcode,
  output logic [4:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_data,
  input  logic                     alu_c,
  input  logic                     alu_z,
  output logic [7:0]               acc,
  output logic                     zflag,
  output logic                     cflag,
  output logic [4:0]               pc,
  output logic                     halted
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_EXEC     = 2'd1,
    S_OUT_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;
  localparam logic [2:0] OP_JZ  = 3'b100;
  localparam logic [2:0] OP_JC  = 3'b101;
  localparam logic [2:0] OP_OUT = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [7:0] out_data_q, out_data_d;

  // ALU operands follow the decoded instruction and accumulator continuously.
  assign alu_opcode = ir_q[7:5];
  assign alu_a      = ir_q[4:0];
  assign alu_b      = acc_q;

  // Request is masked during reset so memory never sees a stray fetch.
  assign bus.imem_req  = reset_n && (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (state_q == S_OUT_WAIT);
  assign bus.out_data  = out_data_q;

  assign acc    = acc_q;
  assign zflag  = z_q;
  assign cflag  = c_q;
  assign pc     = pc_q;
  assign halted = (state_q == S_HALT);

  // Next-state and architectural-state update; everything holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    z_d        = z_q;
    c_d        = c_q;
    out_data_d = out_data_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 5'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[7:5])
          OP_ADD, OP_SUB: begin
            acc_d = alu_data;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_LDI: begin
            acc_d = {3'b000, ir_q[4:0]};
            z_d   = (ir_q[4:0] == 5'd0);
            c_d   = 1'b0;
          end
          OP_JMP: pc_d = ir_q[4:0];
          // Flags tested here are the ones registered before this EXEC.
          OP_JZ:  if (z_q) pc_d = ir_q[4:0];
          OP_JC:  if (c_q) pc_d = ir_q[4:0];
          OP_OUT: begin
            out_data_d = acc_q;
            state_d    = S_OUT_WAIT;
          end
          OP_HLT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_OUT_WAIT: begin
        if (bus.out_ready) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset over all state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= 5'd0;
      ir_q       <= 8'd0;
      acc_q      <= 8'd0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      out_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_never8_control.sv
// Directed bench for never8_control: small program images, a behavioural
// ALU and zero-wait memory, with hand-computed expectations.
module tb_never8_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ack_en = 1'b1;
  logic       out_ready_r = 1'b1;
  logic [7:0] mem [32];

  logic [2:0] alu_opcode;
  logic [4:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_data;
  logic       alu_c;
  logic       alu_z;
  logic [7:0] acc;
  logic       zflag;
  logic       cflag;
  logic [4:0] pc;
  logic       halted;
  logic [8:0] alu_sum;

  int n_vec  = 0;
  int n_miss = 0;

  never8_control_if bus ();

  assign bus.imem_ack  = ack_en;
  assign bus.imem_data = mem[bus.imem_addr];
  assign bus.out_ready = out_ready_r;

  never8_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_data   (alu_data),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .acc        (acc),
    .zflag      (zflag),
    .cflag      (cflag),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: add / subtract with carry meaning no-borrow.
  always_comb begin
    alu_sum = 9'd0;
    alu_c   = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_sum = {1'b0, alu_b} + {4'b0, alu_a};
        alu_c   = alu_sum[8];
      end
      3'b001: begin
        alu_sum = {1'b0, alu_b} - {4'b0, alu_a};
        alu_c   = ~alu_sum[8];
      end
      default: alu_sum = {1'b0, alu_b};
    endcase
    alu_data = alu_sum[7:0];
    alu_z    = (alu_sum[7:0] == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
  endtask

  // Hold reset across one edge, check reset values, then release.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    step(1);
    chk({tag, "_rst_req"},   {31'd0, bus.imem_req},  32'd0);
    chk({tag, "_rst_pc"},    {27'd0, pc},            32'd0);
    chk({tag, "_rst_acc"},   {24'd0, acc},           32'd0);
    chk({tag, "_rst_flags"}, {30'd0, zflag, cflag},  32'd0);
    chk({tag, "_rst_outv"},  {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_rst_outd"},  {24'd0, bus.out_data},  32'd0);
    chk({tag, "_rst_halt"},  {31'd0, halted},        32'd0);
    reset_n = 1'b1;
    #1;
    chk({tag, "_first_req"}, {30'd0, bus.imem_req, 1'b0} | {27'd0, bus.imem_addr}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // LDI 5; ADD 3; OUT; HLT
    clear_mem();
    mem[0] = 8'h45; mem[1] = 8'h03; mem[2] = 8'hC0;
    out_ready_r = 1'b1;
    do_reset("t1");
    step(6);
    chk("t1_outv",  {31'd0, bus.out_valid}, 32'd1);
    chk("t1_outd",  {24'd0, bus.out_data},  32'd8);
    chk("t1_flags", {30'd0, zflag, cflag},  32'd0);
    chk("t1_req_ow", {31'd0, bus.imem_req}, 32'd0);
    step(1);
    chk("t1_outv_fall", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_req_back",  {31'd0, bus.imem_req},  32'd1);
    step(2);
    chk("t1_halted", {31'd0, halted},       32'd1);
    chk("t1_pc",     {27'd0, pc},           32'd4);
    step(5);
    chk("t1_halt_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t1_halt_pc",  {27'd0, pc},           32'd4);
    chk("t1_halt_acc", {24'd0, acc},          32'd8);
    do_reset("t1h");

    // LDI 0; SUB 1; ADD 1
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h21; mem[2] = 8'h01;
    do_reset("t2");
    step(4);
    chk("t2_sub_acc",   {24'd0, acc},          32'hFF);
    chk("t2_sub_flags", {30'd0, zflag, cflag}, 32'd0);
    step(2);
    chk("t2_add_acc",   {24'd0, acc},          32'h00);
    chk("t2_add_flags", {30'd0, zflag, cflag}, 32'd3);

    // LDI 3; SUB 3; JZ 10; @10 JC 20
    clear_mem();
    mem[0] = 8'h43; mem[1] = 8'h23; mem[2] = 8'h8A; mem[10] = 8'hB4;
    do_reset("t3");
    step(4);
    chk("t3_flags", {30'd0, zflag, cflag}, 32'd3);
    step(2);
    chk("t3_jz_addr", {27'd0, bus.imem_addr}, 32'd10);
    step(2);
    chk("t3_jc_addr", {27'd0, bus.imem_addr}, 32'd20);
    chk("t3_jc_acc",  {24'd0, acc},           32'd0);

    // LDI 3; SUB 2; JZ 10 falls through
    clear_mem();
    mem[0] = 8'h43; mem[1] = 8'h22; mem[2] = 8'h8A;
    do_reset("t3b");
    step(6);
    chk("t3b_flags",   {30'd0, zflag, cflag},   32'd1);
    chk("t3b_jz_addr", {27'd0, bus.imem_addr},  32'd3);

    // JMP 31; @31 LDI 7 -> wrap to 0, then stall fetch
    clear_mem();
    mem[0] = 8'h7F; mem[31] = 8'h47;
    do_reset("t4");
    step(2);
    chk("t4_addr31", {27'd0, bus.imem_addr}, 32'd31);
    step(2);
    chk("t4_wrap", {27'd0, bus.imem_addr}, 32'd0);
    chk("t4_acc",  {24'd0, acc},           32'd7);
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_stall_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t4_stall_pc",  {27'd0, pc},           32'd0);
      chk("t4_stall_acc", {24'd0, acc},          32'd7);
    end
    ack_en = 1'b1;
    step(1);
    chk("t4_resume_pc", {27'd0, pc}, 32'd1);
    step(1);
    chk("t4_jmp_pc", {27'd0, pc}, 32'd31);
    ack_en = 1'b0;
    step(2);
    do_reset("t4s");
    ack_en = 1'b1;
    step(1);
    chk("t4s_refetch_pc", {27'd0, pc}, 32'd1);

    // LDI 9; OUT with ready low for three cycles; HLT
    clear_mem();
    mem[0] = 8'h49; mem[1] = 8'hC0;
    out_ready_r = 1'b0;
    do_reset("t5");
    step(4);
    for (int i = 0; i < 3; i++) begin
      chk("t5_outv", {31'd0, bus.out_valid}, 32'd1);
      chk("t5_outd", {24'd0, bus.out_data},  32'd9);
      chk("t5_req",  {31'd0, bus.imem_req},  32'd0);
      if (i < 2) step(1);
    end
    out_ready_r = 1'b1;
    step(1);
    chk("t5_outv_fall", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_fetch_req", {31'd0, bus.imem_req},  32'd1);
    chk("t5_fetch_addr", {27'd0, bus.imem_addr}, 32'd2);
    step(2);
    chk("t5_halted", {31'd0, halted}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/never8_control.md
# never8_control

Fetch/decode/execute sequencer for the Never8 core, sitting directly upstream of the 8-bit ALU. Fetches 8-bit instructions from program memory over a req/ack handshake, drives the ALU operand and opcode inputs, and owns the architectural state that consumes ALU results: accumulator, zero/carry flags and PC. It also provides a valid/ready output port and halt status.

## Interface
- No parameters. Widths are fixed: 8-bit data, 5-bit PC/immediate, 3-bit opcode.
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  5  fetch address; equals pc
- imem_ack  in  1  instruction valid on imem_data this cycle
- imem_data  in  8  instruction: [7:5] opcode, [4:0] imm
- alu_opcode  out  3  to ALU opcode; equals ir[7:5]
- alu_a  out  5  to ALU a; equals ir[4:0]
- alu_b  out  8  to ALU b; equals acc
- alu_data  in  8  ALU data_out (combinational)
- alu_c  in  1  ALU carry
- alu_z  in  1  ALU zero flag
- out_valid  out  1  output port data valid
- out_data  out  8  output port data
- out_ready  in  1  consumer accepts out_data
- acc  out  8  accumulator
- zflag  out  1  registered zero flag
- cflag  out  1  registered carry flag
- pc  out  5  program counter
- halted  out  1  core stopped

## Operation
- ISA (ir[7:5]):
  - 000 ADD: acc←alu_data (acc+imm); z←alu_z; c←alu_c.
  - 001 SUB: acc←alu_data (acc−imm); z←alu_z; c←alu_c. c=1 means no borrow.
  - 010 LDI: acc←{3'b0,imm}; z←(imm==0); c←0.
  - 011 JMP: pc←imm.
  - 100 JZ: if zflag, pc←imm.
  - 101 JC: if cflag, pc←imm.
  - 110 OUT: out_data←acc; enter OUT_WAIT.
  - 111 HLT: enter HALT.
- FSM states: FETCH, EXEC, OUT_WAIT, HALT.
  - FETCH: imem_req=1. On imem_ack: ir←imem_data, pc←pc+1 mod 32, go to EXEC. Without ack, stay in FETCH.
  - EXEC: one cycle. Apply the opcode action. Next state is FETCH, or OUT_WAIT for OUT, or HALT for HLT.
  - OUT_WAIT: out_valid=1, out_data held stable. When out_valid&&out_ready, go to FETCH.
  - HALT: terminal. All state frozen; halted=1. Only reset exits HALT.
- Flags are modified only by ADD, SUB and LDI. Jumps, OUT and HLT leave acc and flags unchanged.
- A jump target overrides the pc+1 increment done in FETCH. JZ/JC test the flags as registered before this EXEC.
- PC wraps 31→0 with no error.
- alu_* outputs are continuous combinational assigns. Results are captured only in EXEC.

## Timing
- Reset (reset_n=0 at a rising edge) sets:
  - state=FETCH, pc=0, ir=0, acc=0, zflag=0, cflag=0, out_data=0.
  - out_valid=0, halted=0.
  - imem_req forced to 0 while reset_n=0.
- First imem_req is asserted in the first cycle after reset_n returns high.
- Reset has priority over all states, including mid-fetch, OUT_WAIT and HALT. A pending ack or output transfer is discarded.
- imem_ack is sampled only in FETCH. Ack in the same cycle as req is allowed, giving a zero-wait fetch. Ack outside FETCH is ignored.
- Minimum 2 cycles per instruction: FETCH(ack) then EXEC. OUT adds at least 1 cycle.
- acc, flags and pc update on the clock edge that ends EXEC, and are visible the next cycle.
- out_valid rises the cycle after OUT's EXEC. It falls the cycle after the handshake completes.
- imem_req is 0 in EXEC, OUT_WAIT and HALT.
- halted rises the cycle after HLT's EXEC.

## Test plan
- Program LDI 5; ADD 3; OUT, zero-wait memory, out_ready=1 → out_data=8, out_valid pulses 1 cycle, zflag=0, cflag=0. OUT appears at cycle 7 after reset release.
- Program LDI 0; SUB 1; ADD 1 → after SUB: acc=0xFF, c=0, z=0. After ADD: acc=0x00, c=1, z=1.
- Program LDI 3; SUB 3; JZ 10; JC 20 → after SUB: z=1, c=1. JZ fetch address is next 10. Then with ir at 10 = JC 20, the next address is 20. With z=0 instead, JZ falls through to address 3.
- Non-jump instruction at address 31 → next imem_addr=0. Ack delayed 4 cycles → imem_req held, pc stable, no state change.
- OUT with out_ready low for 3 cycles → out_valid=1 and out_data stable throughout, imem_req=0. Transfer occurs on the ready cycle, and FETCH resumes next cycle.
- HLT → halted=1, imem_req=0 indefinitely. Then reset_n low during HALT, and separately during a stalled FETCH → all outputs return to reset values, and fetching resumes at pc=0.
